// File: rtl/fp_round_pack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fp_round_pack: round-half-up, carry renormalise and saturate, then pack   |
// | {S,E,F} through a 2-stage valid/ready pipe. ROUND_STATS_EN adds counters. |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module fp_round_pack #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [2:0]       raw_E,
  input  logic [3:0]       raw_F,
  input  logic             rndg_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       fp_out,
  output logic             sat
`ifdef ROUND_STATS_EN
  ,
  output logic [CNT_W-1:0] round_cnt,
  output logic [CNT_W-1:0] sat_cnt
`endif
);

  logic       s1_valid_q, s1_sign_q, s1_inc_q, s1_cy_q, s1_ovf_q;
  logic [2:0] s1_e_q;
  logic [3:0] s1_f_q;
  logic       s2_valid_q, sat_q;
  logic [7:0] fp_q;
  logic       s2_adv, in_fire, out_fire;
  logic [2:0] e_d;
  logic [3:0] f_d;
  logic       sat_d;

  assign s2_adv    = s1_valid_q & (~s2_valid_q | out_ready);
  assign in_ready  = ~s1_valid_q | s2_adv;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = s2_valid_q & out_ready;
  assign out_valid = s2_valid_q;
  assign fp_out    = fp_q;
  assign sat       = sat_q;

  // A carry out of F only happens when F is all ones, so the default path never wraps.
  always_comb begin
    e_d   = s1_e_q;
    f_d   = s1_f_q + {3'b000, s1_inc_q};
    sat_d = 1'b0;
    if (s1_ovf_q) begin
      e_d   = 3'd7;
      f_d   = 4'hF;
      sat_d = 1'b1;
    end else if (s1_cy_q) begin
      e_d = s1_e_q + 3'd1;
      f_d = 4'b1000;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_e_q     <= 3'd0;
      s1_f_q     <= 4'd0;
      s1_inc_q   <= 1'b0;
      s1_cy_q    <= 1'b0;
      s1_ovf_q   <= 1'b0;
    end else if (in_fire) begin
      s1_valid_q <= 1'b1;
      s1_sign_q  <= in_sign;
      s1_e_q     <= raw_E;
      s1_f_q     <= raw_F;
      s1_inc_q   <= rndg_bit;
      s1_cy_q    <= (raw_F == 4'hF) & rndg_bit;
      s1_ovf_q   <= (raw_F == 4'hF) & rndg_bit & (raw_E == 3'd7);
    end else if (s2_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      fp_q       <= 8'h00;
      sat_q      <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= 1'b1;
      fp_q       <= {s1_sign_q, e_d, f_d};
      sat_q      <= sat_d;
    end else if (out_fire) begin
      s2_valid_q <= 1'b0;
    end
  end

`ifdef ROUND_STATS_EN
  logic [CNT_W-1:0] round_cnt_q, sat_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      round_cnt_q <= '0;
      sat_cnt_q   <= '0;
    end else begin
      if (in_fire & rndg_bit) round_cnt_q <= round_cnt_q + 1'b1;
      if (out_fire & sat_q)   sat_cnt_q   <= sat_cnt_q + 1'b1;
    end
  end

  assign round_cnt = round_cnt_q;
  assign sat_cnt   = sat_cnt_q;
`endif

endmodule
`default_nettype wire
